// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory access stage: Funct3 encodings,
// FSM state encoding and access-size decoding.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } stage_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } access_size_t;

  // Any encoding not explicitly listed for the access direction falls back to word size.
  function automatic access_size_t decode_size(input logic is_store, input logic [2:0] funct3);
    access_size_t sz;
    sz = SZ_WORD;
    if (is_store) begin
      if (funct3 == F3_SB)      sz = SZ_BYTE;
      else if (funct3 == F3_SH) sz = SZ_HALF;
    end else begin
      if (funct3 == F3_LB || funct3 == F3_LBU)      sz = SZ_BYTE;
      else if (funct3 == F3_LH || funct3 == F3_LHU) sz = SZ_HALF;
    end
    return sz;
  endfunction

  function automatic logic load_is_signed(input logic [2:0] funct3);
    return (funct3 == F3_LB) || (funct3 == F3_LH);
  endfunction

endpackage

// File: rtl/data_mem_banked.sv
// Data memory built from four byte-wide banks: synchronous write with
// per-lane enable, combinational read. Contents are never reset.
module data_mem_banked #(
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  for (genvar b = 0; b < 4; b++) begin : g_bank
    logic [7:0] bank [DEPTH];

    // Write one byte lane when the store enables it.
    always_ff @(posedge clk) begin
      if (we && be[b]) bank[addr] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = bank[addr];
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline M->W stage with a byte-addressed data memory of configurable
// latency. LAT=1 behaves as a plain single-cycle stage; longer latencies
// hold the pipeline with StallM while a small FSM counts the access out.
//
// state | meaning
// IDLE  | no access in flight; a new access may start or complete here (LAT=1)
// BUSY  | multi-cycle access in flight; counter tracks cycles elapsed
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int LAT   = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic            MemReadM,
  input  logic            ResultSrcM,
  input  logic [2:0]      Funct3M,
  input  logic [4:0]      RD_M,
  input  logic [XLEN-1:0] PCPlus4M,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [XLEN-1:0] ALU_ResultM,
  output logic            StallM,
  output logic            MisalignM,
  output logic            RegWriteW,
  output logic            ResultSrcW,
  output logic [4:0]      RD_W,
  output logic [XLEN-1:0] PCPlus4W,
  output logic [XLEN-1:0] ReadDataW,
  output logic [XLEN-1:0] ALU_ResultW
);

  localparam int         AW       = $clog2(DEPTH);
  localparam logic       MULTI    = (LAT > 1);
  localparam logic [1:0] CNT_LAST = 2'(LAT - 1);

  if (XLEN != 32) begin : g_bad_xlen
    $error("mem_access_stage: XLEN must be 32");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("mem_access_stage: DEPTH must be a power of two");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("mem_access_stage: LAT must be in 1..4");
  end

  stage_state_t   state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic           mem_op, access, stall, complete, mem_we;
  access_size_t   acc_size;
  logic [1:0]     byte_off;
  logic [AW-1:0]  word_idx;
  logic [3:0]     byte_en;
  logic [31:0]    wdata_lanes;
  logic [31:0]    rd_word, rd_shift, load_data;
  logic [7:0]     byte_sel;
  logic [15:0]    half_sel;
  logic           unused_addr_bits;

  // A request with both strobes high is handled as a store.
  assign mem_op   = MemReadM | MemWriteM;
  assign acc_size = decode_size(MemWriteM, Funct3M);
  assign byte_off = ALU_ResultM[1:0];
  assign word_idx = ALU_ResultM[AW+1:2];

  assign unused_addr_bits = ^ALU_ResultM[XLEN-1:AW+2];

  assign MisalignM = mem_op &&
                     (((acc_size == SZ_HALF) && byte_off[0]) ||
                      ((acc_size == SZ_WORD) && (byte_off != 2'b00)));
  assign access    = mem_op & ~MisalignM;

  // Byte enables and lane-replicated store data.
  always_comb begin
    byte_en     = 4'b1111;
    wdata_lanes = WriteDataM;
    case (acc_size)
      SZ_BYTE: begin
        byte_en     = 4'b0001 << byte_off;
        wdata_lanes = {4{WriteDataM[7:0]}};
      end
      SZ_HALF: begin
        byte_en     = byte_off[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{WriteDataM[15:0]}};
      end
      default: begin
        byte_en     = 4'b1111;
        wdata_lanes = WriteDataM;
      end
    endcase
  end

  data_mem_banked #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .be    (byte_en),
    .addr  (word_idx),
    .wdata (wdata_lanes),
    .rdata (rd_word)
  );

  assign rd_shift = rd_word >> {byte_off, 3'b000};
  assign byte_sel = rd_shift[7:0];
  assign half_sel = byte_off[1] ? rd_word[31:16] : rd_word[15:0];

  // Extract and extend the addressed byte/halfword for loads.
  always_comb begin
    load_data = rd_word;
    case (acc_size)
      SZ_BYTE: load_data = load_is_signed(Funct3M) ? {{24{byte_sel[7]}}, byte_sel}
                                                   : {24'h0, byte_sel};
      SZ_HALF: load_data = load_is_signed(Funct3M) ? {{16{half_sel[15]}}, half_sel}
                                                   : {16'h0, half_sel};
      default: load_data = rd_word;
    endcase
  end

  // FSM state and cycle counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state: a multi-cycle access enters BUSY at count 1 and leaves on the last count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (access && MULTI) begin
          state_d = BUSY;
          cnt_d   = 2'd1;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // Outputs: stall until the completion cycle; reset suppresses both stall and completion.
  always_comb begin
    stall    = 1'b0;
    complete = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (MULTI) stall    = 1'b1;
          else       complete = 1'b1;
        end
      end
      BUSY: begin
        if (cnt_q == CNT_LAST) complete = 1'b1;
        else                   stall    = 1'b1;
      end
      default: begin
        stall    = 1'b0;
        complete = 1'b0;
      end
    endcase
    if (!rst) begin
      stall    = 1'b0;
      complete = 1'b0;
    end
  end

  assign StallM = stall;
  assign mem_we = complete & access & MemWriteM;

  // W register: bubble while stalled, otherwise capture the M fields.
  always_ff @(posedge clk) begin
    if (!rst || stall) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= 5'd0;
      PCPlus4W    <= '0;
      ReadDataW   <= '0;
      ALU_ResultW <= '0;
    end else begin
      RegWriteW   <= RegWriteM & ~MisalignM;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ReadDataW   <= load_data;
      ALU_ResultW <= ALU_ResultM;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a vector table on a LAT=1 instance,
// plus hand-written sequences for LAT=3 stalls/reset abort and DEPTH=16 wrap.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, MemReadM, ResultSrcM;
  logic [2:0]  Funct3M;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

  logic        stall_1, mis_1, rww_1, rsw_1;
  logic [4:0]  rdw_1;
  logic [31:0] pc4w_1, rdataw_1, aluw_1;
  logic        stall_3, mis_3, rww_3, rsw_3;
  logic [4:0]  rdw_3;
  logic [31:0] pc4w_3, rdataw_3, aluw_3;
  logic        stall_16, mis_16, rww_16, rsw_16;
  logic [4:0]  rdw_16;
  logic [31:0] pc4w_16, rdataw_16, aluw_16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.XLEN(32), .DEPTH(1024), .LAT(1)) u_lat1 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(stall_1), .MisalignM(mis_1),
    .RegWriteW(rww_1), .ResultSrcW(rsw_1), .RD_W(rdw_1), .PCPlus4W(pc4w_1),
    .ReadDataW(rdataw_1), .ALU_ResultW(aluw_1));

  mem_access_stage #(.XLEN(32), .DEPTH(1024), .LAT(3)) u_lat3 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(stall_3), .MisalignM(mis_3),
    .RegWriteW(rww_3), .ResultSrcW(rsw_3), .RD_W(rdw_3), .PCPlus4W(pc4w_3),
    .ReadDataW(rdataw_3), .ALU_ResultW(aluw_3));

  mem_access_stage #(.XLEN(32), .DEPTH(16), .LAT(1)) u_d16 (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .MemReadM(MemReadM),
    .ResultSrcM(ResultSrcM), .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
    .WriteDataM(WriteDataM), .ALU_ResultM(ALU_ResultM), .StallM(stall_16), .MisalignM(mis_16),
    .RegWriteW(rww_16), .ResultSrcW(rsw_16), .RD_W(rdw_16), .PCPlus4W(pc4w_16),
    .ReadDataW(rdataw_16), .ALU_ResultW(aluw_16));

  typedef struct {
    logic        we, re, rw, rs;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] wd, addr;
    logic        chk_rd;
    logic        mis;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 25;
  vec_t vt [NV];

  function automatic vec_t mk(input logic we, input logic re, input logic rw, input logic rs,
                              input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] wd,
                              input logic [31:0] addr, input logic chk_rd, input logic mis,
                              input logic [31:0] rdata);
    vec_t v;
    v.we = we; v.re = re; v.rw = rw; v.rs = rs; v.f3 = f3; v.rd = rd;
    v.wd = wd; v.addr = addr; v.chk_rd = chk_rd; v.mis = mis; v.rdata = rdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic re, input logic rw, input logic rs,
                       input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] pc4,
                       input logic [31:0] wd, input logic [31:0] addr);
    MemWriteM = we; MemReadM = re; RegWriteM = rw; ResultSrcM = rs;
    Funct3M = f3; RD_M = rd; PCPlus4M = pc4; WriteDataM = wd; ALU_ResultM = addr;
  endtask

  task automatic idle_in();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
  endtask

  // Hold the presented access on the LAT=3 instance until it completes.
  task automatic op3(input string nm, input int exp_st, input logic exp_rww,
                     input logic do_rd, input logic [31:0] exp_rd);
    int  st;
    bit  done;
    st   = 0;
    done = 1'b0;
    for (int c = 0; c < 8 && !done; c++) begin
      #1;
      if (stall_3) begin
        st++;
        tick();
        chk({nm, " bubble RegWriteW"}, {31'h0, rww_3}, 32'h0);
        chk({nm, " bubble ALU_ResultW"}, aluw_3, 32'h0);
      end else begin
        tick();
        done = 1'b1;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: stall still high after 8 cycles", nm);
    end
    chk({nm, " stall cycles"}, 32'(st), 32'(exp_st));
    chk({nm, " RegWriteW"}, {31'h0, rww_3}, {31'h0, exp_rww});
    if (do_rd) chk({nm, " ReadDataW"}, rdataw_3, exp_rd);
    idle_in();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // we re rw rs f3 rd wd addr chk_rd mis rdata
    vt[0]  = mk(1, 0, 0, 0, 3'b010, 5'd0,  32'hDEADBEEF, 32'h10,       0, 0, 32'h0);
    vt[1]  = mk(0, 1, 1, 1, 3'b010, 5'd5,  32'h0,        32'h10,       1, 0, 32'hDEADBEEF);
    vt[2]  = mk(1, 0, 0, 0, 3'b010, 5'd0,  32'h0,        32'h10,       0, 0, 32'h0);
    vt[3]  = mk(1, 0, 0, 0, 3'b000, 5'd0,  32'h80,       32'h13,       0, 0, 32'h0);
    vt[4]  = mk(0, 1, 1, 1, 3'b000, 5'd6,  32'h0,        32'h13,       1, 0, 32'hFFFFFF80);
    vt[5]  = mk(0, 1, 1, 1, 3'b100, 5'd7,  32'h0,        32'h13,       1, 0, 32'h00000080);
    vt[6]  = mk(0, 1, 1, 1, 3'b010, 5'd8,  32'h0,        32'h10,       1, 0, 32'h80000000);
    vt[7]  = mk(1, 0, 0, 0, 3'b010, 5'd0,  32'h11223344, 32'h20,       0, 0, 32'h0);
    vt[8]  = mk(1, 0, 0, 0, 3'b001, 5'd0,  32'h1234BEEF, 32'h22,       0, 0, 32'h0);
    vt[9]  = mk(0, 1, 1, 1, 3'b001, 5'd9,  32'h0,        32'h22,       1, 0, 32'hFFFFBEEF);
    vt[10] = mk(0, 1, 1, 1, 3'b101, 5'd10, 32'h0,        32'h22,       1, 0, 32'h0000BEEF);
    vt[11] = mk(0, 1, 1, 1, 3'b001, 5'd11, 32'h0,        32'h20,       1, 0, 32'h00003344);
    vt[12] = mk(0, 1, 1, 1, 3'b000, 5'd12, 32'h0,        32'h21,       1, 0, 32'h00000033);
    vt[13] = mk(0, 1, 1, 1, 3'b001, 5'd12, 32'h0,        32'h21,       0, 1, 32'h0);
    vt[14] = mk(1, 0, 0, 0, 3'b010, 5'd0,  32'hFFFFFFFF, 32'h22,       0, 1, 32'h0);
    vt[15] = mk(0, 1, 1, 1, 3'b010, 5'd13, 32'h0,        32'h23,       0, 1, 32'h0);
    vt[16] = mk(0, 1, 1, 1, 3'b010, 5'd14, 32'h0,        32'h20,       1, 0, 32'hBEEF3344);
    vt[17] = mk(0, 0, 1, 0, 3'b001, 5'd7,  32'h0,        32'h21,       0, 0, 32'h0);
    vt[18] = mk(0, 1, 1, 1, 3'b011, 5'd15, 32'h0,        32'h20,       1, 0, 32'hBEEF3344);
    vt[19] = mk(0, 1, 1, 1, 3'b110, 5'd16, 32'h0,        32'h22,       0, 1, 32'h0);
    vt[20] = mk(1, 1, 0, 0, 3'b100, 5'd0,  32'hCAFEF00D, 32'h24,       0, 0, 32'h0);
    vt[21] = mk(0, 1, 1, 1, 3'b010, 5'd17, 32'h0,        32'h24,       1, 0, 32'hCAFEF00D);
    vt[22] = mk(0, 1, 1, 1, 3'b010, 5'd18, 32'h0,        32'h00100010, 1, 0, 32'h80000000);
    vt[23] = mk(0, 1, 1, 1, 3'b000, 5'd19, 32'h0,        32'h25,       1, 0, 32'hFFFFFFF0);
    vt[24] = mk(0, 1, 1, 1, 3'b101, 5'd20, 32'h0,        32'h26,       1, 0, 32'h0000CAFE);

    // Reset with an access presented: W stays zero, no stall.
    rst = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h44, 32'h0, 32'h50);
    tick();
    tick();
    chk("reset StallM lat3", {31'h0, stall_3}, 32'h0);
    chk("reset RegWriteW lat3", {31'h0, rww_3}, 32'h0);
    chk("reset ResultSrcW lat3", {31'h0, rsw_3}, 32'h0);
    chk("reset RD_W lat3", {27'h0, rdw_3}, 32'h0);
    chk("reset PCPlus4W lat3", pc4w_3, 32'h0);
    chk("reset ALU_ResultW lat3", aluw_3, 32'h0);
    chk("reset ReadDataW lat3", rdataw_3, 32'h0);
    chk("reset RegWriteW lat1", {31'h0, rww_1}, 32'h0);
    chk("reset PCPlus4W lat1", pc4w_1, 32'h0);
    rst = 1'b1;
    idle_in();
    tick();

    // Table on the single-cycle instance.
    for (int i = 0; i < NV; i++) begin
      drive(vt[i].we, vt[i].re, vt[i].rw, vt[i].rs, vt[i].f3, vt[i].rd,
            32'h1000 + 32'(4 * i), vt[i].wd, vt[i].addr);
      #1;
      chk($sformatf("v%0d MisalignM", i), {31'h0, mis_1}, {31'h0, vt[i].mis});
      chk($sformatf("v%0d StallM", i), {31'h0, stall_1}, 32'h0);
      tick();
      chk($sformatf("v%0d RegWriteW", i), {31'h0, rww_1}, {31'h0, vt[i].rw & ~vt[i].mis});
      chk($sformatf("v%0d ResultSrcW", i), {31'h0, rsw_1}, {31'h0, vt[i].rs});
      chk($sformatf("v%0d RD_W", i), {27'h0, rdw_1}, {27'h0, vt[i].rd});
      chk($sformatf("v%0d PCPlus4W", i), pc4w_1, 32'h1000 + 32'(4 * i));
      chk($sformatf("v%0d ALU_ResultW", i), aluw_1, vt[i].addr);
      if (vt[i].chk_rd) chk($sformatf("v%0d ReadDataW", i), rdataw_1, vt[i].rdata);
    end

    // DEPTH=16: address 0x40 aliases word 0.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h0, 32'hA5A5A5A5, 32'h40);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 5'd3, 32'h0, 32'h0, 32'h00);
    tick();
    chk("d16 wrap ReadDataW", rdataw_16, 32'hA5A5A5A5);
    chk("d16 wrap RD_W", {27'h0, rdw_16}, 32'd3);

    // Return every instance to a clean state before the LAT=3 sequences.
    rst = 1'b0;
    idle_in();
    tick();
    rst = 1'b1;
    tick();

    // LAT=3 store then load of the same word.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h300, 32'h11111111, 32'h50);
    op3("lat3 sw", 2, 1'b0, 1'b0, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 5'd9, 32'h304, 32'h0, 32'h50);
    op3("lat3 lw", 2, 1'b1, 1'b1, 32'h11111111);
    chk("lat3 lw RD_W", {27'h0, rdw_3}, 32'd9);
    chk("lat3 lw PCPlus4W", pc4w_3, 32'h304);

    // Reset one cycle into a store: aborted, no write.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h308, 32'h22222222, 32'h50);
    #1;
    chk("abort first-cycle StallM", {31'h0, stall_3}, 32'h1);
    tick();
    rst = 1'b0;
    #1;
    chk("abort StallM in reset", {31'h0, stall_3}, 32'h0);
    tick();
    chk("abort RegWriteW", {31'h0, rww_3}, 32'h0);
    chk("abort PCPlus4W", pc4w_3, 32'h0);
    chk("abort ALU_ResultW", aluw_3, 32'h0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 5'd4, 32'h30C, 32'h0, 32'h50);
    op3("lat3 lw after abort", 2, 1'b1, 1'b1, 32'h11111111);

    // Misaligned accesses on LAT=3: no stall, no write, RegWriteW dropped.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b001, 5'd6, 32'h310, 32'h0, 32'h21);
    #1;
    chk("lat3 lh mis MisalignM", {31'h0, mis_3}, 32'h1);
    chk("lat3 lh mis StallM", {31'h0, stall_3}, 32'h0);
    tick();
    chk("lat3 lh mis RegWriteW", {31'h0, rww_3}, 32'h0);
    chk("lat3 lh mis RD_W", {27'h0, rdw_3}, 32'd6);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 5'd0, 32'h314, 32'hFFFFFFFF, 32'h52);
    #1;
    chk("lat3 sw mis StallM", {31'h0, stall_3}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 3'b010, 5'd5, 32'h318, 32'h0, 32'h50);
    op3("lat3 lw after mis", 2, 1'b1, 1'b1, 32'h11111111);

    // Non-access cycle on LAT=3 passes straight through.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 5'd11, 32'h2000, 32'h0, 32'h77);
    #1;
    chk("lat3 pass StallM", {31'h0, stall_3}, 32'h0);
    tick();
    chk("lat3 pass RegWriteW", {31'h0, rww_3}, 32'h1);
    chk("lat3 pass RD_W", {27'h0, rdw_3}, 32'd11);
    chk("lat3 pass ALU_ResultW", aluw_3, 32'h77);
    chk("lat3 pass PCPlus4W", pc4w_3, 32'h2000);
    idle_in();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
